// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: decode inputs and datapath control outputs of the multicycle sequencer.
interface multicycle_controller_if;
    logic [1:0] op;
    logic       funct_5;
    logic       funct_0;
    logic       mem_ready;
    logic       ir_w;
    logic       next_pc;
    logic       branch;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic       undef;

    modport master (
        input  op, funct_5, funct_0, mem_ready,
        output ir_w, next_pc, branch, adr_src, alu_src_a, alu_src_b, result_src,
               alu_op, reg_w, mem_w, imm_src, reg_src, undef
    );
    modport slave (
        output op, funct_5, funct_0, mem_ready,
        input  ir_w, next_pc, branch, adr_src, alu_src_a, alu_src_b, result_src,
               alu_op, reg_w, mem_w, imm_src, reg_src, undef
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore main sequencer stepping each ARM instruction through
// fetch/decode/execute/memory/writeback, driving the shared-datapath selects and enables.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    multicycle_controller_if.master   bus,
    output logic [STATE_W-1:0]        state
);
    localparam logic [STATE_W-1:0] FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] EXECUTER = STATE_W'(6);
    localparam logic [STATE_W-1:0] EXECUTEI = STATE_W'(7);
    localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] BRANCH   = STATE_W'(9);

    logic [STATE_W-1:0] state_q, state_d;
    logic ir_w_c, next_pc_c, branch_c, reg_w_c, mem_w_c, undef_c;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;

    always_comb begin
        state_d        = FETCH;
        ir_w_c         = 1'b0;
        next_pc_c      = 1'b0;
        branch_c       = 1'b0;
        reg_w_c        = 1'b0;
        mem_w_c        = 1'b0;
        undef_c        = 1'b0;
        bus.adr_src    = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.result_src = 2'b00;
        bus.alu_op     = 1'b0;
        case (state_q)
            FETCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                ir_w_c         = bus.mem_ready;
                next_pc_c      = bus.mem_ready;
                state_d        = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                undef_c        = bus.op == 2'b11;
                state_d        = bus.op == 2'b00 ? (bus.funct_5 ? EXECUTEI : EXECUTER) :
                                 bus.op == 2'b01 ? MEMADR :
                                 bus.op == 2'b10 ? BRANCH : FETCH;
            end
            MEMADR: begin
                bus.alu_src_b  = bus.funct_5 ? 2'b00 : 2'b01;
                state_d        = bus.funct_0 ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.adr_src    = 1'b1;
                state_d        = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                bus.result_src = 2'b01;
                reg_w_c        = 1'b1;
            end
            MEMWRITE: begin
                bus.adr_src    = 1'b1;
                mem_w_c        = 1'b1;
                state_d        = bus.mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                bus.alu_op     = 1'b1;
                state_d        = ALUWB;
            end
            EXECUTEI: begin
                bus.alu_src_b  = 2'b01;
                bus.alu_op     = 1'b1;
                state_d        = ALUWB;
            end
            ALUWB: reg_w_c = 1'b1;
            BRANCH: begin
                bus.alu_src_b  = 2'b01;
                bus.result_src = 2'b10;
                branch_c       = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write enables must be quiet for the whole time reset is held, not just after the next edge.
    assign bus.ir_w    = reset_n & ir_w_c;
    assign bus.next_pc = reset_n & next_pc_c;
    assign bus.branch  = reset_n & branch_c;
    assign bus.reg_w   = reset_n & reg_w_c;
    assign bus.mem_w   = reset_n & mem_w_c;
    assign bus.undef   = reset_n & undef_c;
    assign bus.imm_src = bus.op == 2'b11 ? 2'b00 : bus.op;
    assign bus.reg_src = {bus.op == 2'b01 && !bus.funct_0, bus.op == 2'b10};
    assign state       = state_q;
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style main sequencer for the multicycle ARM core.
- Replaces the single-cycle main decoder: steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives the mux selects and write enables of the shared datapath: one memory port for instruction and data, one ALU that also computes PC+4.
- Stalls on a memory ready handshake. Condition gating (cond_ex) and ALU function decode remain in the existing condition and ALU decoder blocks.

Parameters:
- STATE_W, 4, width of state register and debug state port (must be >= 4).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  2  instr[27:26]: 00 DP, 01 memory, 10 branch, 11 undefined.
- funct_5  in  1  instr[25]: immediate flag.
- funct_0  in  1  instr[20]: load/S flag.
- mem_ready  in  1  memory completes current access this cycle.
- ir_w  out  1  load instruction register.
- next_pc  out  1  PC write request (unconditional).
- branch  out  1  PC write request, qualified downstream by cond_ex.
- adr_src  out  1  memory address: 0 PC, 1 ALU result register.
- alu_src_a  out  1  0 register A (Rn), 1 PC.
- alu_src_b  out  2  00 register WD, 01 ext_imm, 10 constant 4.
- result_src  out  2  00 ALU out register, 01 data register, 10 ALU result (combinational).
- alu_op  out  1  1 = ALU decoder uses funct; 0 = add.
- reg_w  out  1  register-file write, qualified downstream by cond_ex.
- mem_w  out  1  memory write strobe, qualified downstream by cond_ex.
- imm_src  out  2  00 DP, 01 memory, 10 branch.
- reg_src  out  2  bit1: read Rd as RA2 (store); bit0: read PC as RA1 (branch).
- undef  out  1  one-cycle pulse when op=11 is decoded.
- state  out  STATE_W  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Values 10..15 are illegal and transition to FETCH next cycle with all enables 0.
- reset_n=0: state forced to FETCH immediately. ir_w, next_pc, branch, reg_w, mem_w and undef are forced 0 while reset is asserted. Reset mid-instruction abandons the instruction with no write.
- Outputs decode from the state register only, except:
  - ir_w/next_pc are gated by mem_ready;
  - imm_src and reg_src are combinational from op/funct_0 in every state.
  - imm_src: op 00 -> 00, 01 -> 01, 10 -> 10.
  - reg_src = {op==01 & !funct_0, op==10}.
- Unlisted enables are 0. Unlisted selects are 0, except as stated per state.
- FETCH:
  - adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10.
  - ir_w=next_pc=mem_ready.
  - Advance to DECODE only when mem_ready=1; otherwise hold.
- DECODE:
  - alu_src_a=1, alu_src_b=10, result_src=10 (computes PC+8).
  - Next state: op00 & !funct_5 -> EXECUTER; op00 & funct_5 -> EXECUTEI; op01 -> MEMADR; op10 -> BRANCH; op11 -> FETCH with undef=1 this cycle.
- MEMADR:
  - alu_src_a=0; alu_src_b = funct_5 ? 00 : 01 (register-offset vs immediate).
  - Next: funct_0 ? MEMREAD : MEMWRITE.
- MEMREAD:
  - adr_src=1, result_src=00.
  - Hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_w=1; next FETCH.
- MEMWRITE:
  - adr_src=1, result_src=00, mem_w=1 held every cycle until mem_ready.
  - Next FETCH when mem_ready=1.
- EXECUTER: alu_src_a=0, alu_src_b=00, alu_op=1; next ALUWB.
- EXECUTEI: alu_src_a=0, alu_src_b=01, alu_op=1; next ALUWB.
- ALUWB: result_src=00, reg_w=1; next FETCH.
- BRANCH: alu_src_a=0, alu_src_b=01, result_src=10, branch=1; next FETCH.
- Inputs op/funct are sampled every cycle; the IR holds them stable from DECODE onward. mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Zero-wait cycle counts:
  - DP: 4.
  - LDR: 5.
  - STR: 4.
  - B: 3.
  - undefined: 2.
  - Each wait cycle adds exactly 1.

Test Plan:
- Reset: reset_n=0 asynchronously mid-EXECUTER -> state=0 within the same cycle, all enables 0; release with mem_ready=1 -> ir_w=1 on first edge.
- ADD reg (op=00, funct_5=0), mem_ready=1 -> states 0,1,6,8,0; reg_w=1 only in state 8; alu_op=1 only in state 6.
- LDR imm (op=01, funct_5=0, funct_0=1) with mem_ready low 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; result_src=01 and reg_w=1 in state 4.
- STR (op=01, funct_0=0), mem_ready low 1 cycle in MEMWRITE -> mem_w=1 for 2 consecutive cycles, adr_src=1, reg_src=10, reg_w never 1.
- B (op=10), mem_ready low 3 cycles in FETCH -> ir_w/next_pc 0 for 3 cycles then 1 once; states 0,0,0,0,1,9,0; branch=1 in state 9; imm_src=10, reg_src=01.
- Undefined (op=11) -> undef=1 for exactly one cycle in DECODE, next state FETCH, no reg_w/mem_w; LDR reg (funct_5=1, funct_0=1) -> alu_src_b=00 in MEMADR.
